seq_match_fsm: RTL and testbench
================================

SEQ_MATCH_FSM -- requirements
Module: seq_match_fsm

Interface
REQ-001 SHALL have parameter W, default 2: symbol width in bits (W >= 1).
REQ-002 SHALL have parameter DEPTH, default 4: pattern length in symbols (DEPTH >= 1).
REQ-003 SHALL have parameter TIMEOUT, default 8: consecutive idle cycles allowed mid-pattern (TIMEOUT >= 1).
REQ-004 SHALL have parameter STICKY, default 0: 1 = HIT state holds until clear.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port clear  input  1  synchronous soft clear of FSM and error flag; pattern kept.
REQ-008 SHALL have port cfg_we  input  1  pattern write strobe.
REQ-009 SHALL have port cfg_idx  input  max(1,$clog2(DEPTH))  pattern slot index.
REQ-010 SHALL have port cfg_sym  input  W  pattern symbol to write.
REQ-011 SHALL have port in_valid  input  1  in_sym valid this cycle.
REQ-012 SHALL have port in_sym  input  W  input symbol.
REQ-013 SHALL have port in_ready  output  1  symbol accepted when in_valid && in_ready.
REQ-014 SHALL have port match  output  1  high while in HIT.
REQ-015 SHALL have port progress  output  $clog2(DEPTH+1)  count of pattern symbols matched so far.
REQ-016 SHALL have port status  output  3  state code: IDLE 000, MATCHING 001, HIT 010, TIMEOUT 011.
REQ-017 SHALL have port timeout_err  output  1  sticky timeout flag.

Function
REQ-018 SHALL implement a Moore FSM with states IDLE, MATCHING, HIT, TIMEOUT; outputs decode from registered state/progress only.
REQ-019 SHALL force any unused state encoding to IDLE on the next edge, with progress 0.
REQ-020 SHALL hold pattern registers pat[0..DEPTH-1], each W bits.
REQ-021 SHALL write cfg_sym into pat[cfg_idx] on cfg_we only in IDLE; cfg_idx >= DEPTH or non-IDLE writes are ignored.
REQ-022 SHALL drive in_ready=1 in IDLE and MATCHING, 0 in HIT and TIMEOUT; symbols are not accepted while in_ready=0.
REQ-023 SHALL, in IDLE on an accepted symbol equal to pat[0], set progress=1 and go to MATCHING; if DEPTH==1, go to HIT instead.
REQ-024 SHALL, in MATCHING on an accepted symbol equal to pat[progress], increment progress; on reaching DEPTH go to HIT.
REQ-025 SHALL, in MATCHING on mismatch, set progress=1 and stay in MATCHING if symbol equals pat[0]; otherwise set progress=0 and go to IDLE.
REQ-026 SHALL count consecutive MATCHING cycles with in_valid=0 (counter cleared on any accepted symbol and on leaving MATCHING); the edge ending the TIMEOUT-th such cycle enters TIMEOUT, sets timeout_err, and sets progress=0.
REQ-027 SHALL assert match the cycle after the edge accepting the final symbol (1-cycle latency).
REQ-028 SHALL, with STICKY=0, leave HIT after exactly one cycle: progress=0, go to IDLE.
REQ-029 SHALL, with STICKY=1, remain in HIT until clear.
REQ-030 SHALL remain in TIMEOUT until clear; in_valid is ignored there.
REQ-031 SHALL, on clear, go to IDLE, set progress=0, clear timeout_err and the idle counter; clear overrides any simultaneous symbol or cfg write.
REQ-032 SHALL keep progress equal to DEPTH while in HIT.

Reset
REQ-033 SHALL, on reset, set state IDLE, progress 0, idle counter 0, timeout_err 0, and all pat[] to 0; reset overrides clear, cfg_we, and in_valid.
REQ-034 SHALL reset-state outputs as: match 0, status 000, in_ready 1.
REQ-035 SHALL, on reset mid-pattern or in HIT/TIMEOUT, return to IDLE on the next edge with no match pulse.

Verification (defaults; pattern 3,1,2,0 written in IDLE)
REQ-036 SHALL cover: symbols 3,1,2,0 on consecutive cycles -> progress 1,2,3,4; match=1 for exactly one cycle after the 4th edge; status 010, then 000.
REQ-037 SHALL cover: symbols 3,1,3,1,2,0 -> mismatch on the 3rd symbol restarts with progress=1; match after the 6th symbol.
REQ-038 SHALL cover: symbols 3,1 then in_valid=0 for 8 cycles -> status 011, timeout_err=1, in_ready=0; clear -> status 000, timeout_err=0.
REQ-039 SHALL cover: in_valid=0 for 7 cycles then 2,0 -> no timeout; match asserted.
REQ-040 SHALL cover: STICKY=1 with a full match -> match held 20 cycles until clear; clear plus in_valid=3 on the same cycle -> IDLE, progress 0.
REQ-041 SHALL cover: cfg_we during MATCHING is ignored (pattern unchanged); reset after 3,1,2 -> progress 0, no match, pat[] all 0.

Source files
------------

// File: rtl/seq_match_fsm.sv
// Pattern-matching FSM: compares a stream of W-bit symbols against a programmable
// DEPTH-symbol pattern, with an idle timeout while a match is in progress.
module seq_match_fsm #(
  parameter int W       = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8,
  parameter int STICKY  = 0,
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PW     = $clog2(DEPTH + 1),
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [W-1:0]  cfg_sym,
  input  logic          in_valid,
  input  logic [W-1:0]  in_sym,
  output logic          in_ready,
  output logic          match,
  output logic [PW-1:0] progress,
  output logic [2:0]    status,
  output logic          timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_MATCHING = 3'b001,
    S_HIT      = 3'b010,
    S_TIMEOUT  = 3'b011
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_progress;
  logic [CW-1:0] r_idle_cnt;
  logic          r_err;
  logic [W-1:0]  r_pat [DEPTH];

  state_t        w_state_nxt;
  logic [PW-1:0] w_prog_nxt;
  logic [PW-1:0] w_prog_inc;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_err_nxt;
  logic [W-1:0]  w_exp_sym;

  // Pattern slots are only writable while idle, and clear wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pat[i] <= '0;
    end else if (cfg_we && !clear && r_state == S_IDLE) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (32'(cfg_idx) == i) r_pat[i] <= cfg_sym;
    end
  end

  always_comb begin
    w_exp_sym = r_pat[0];
    for (int unsigned i = 0; i < DEPTH; i++)
      if (32'(r_progress) == i) w_exp_sym = r_pat[i];
  end

  assign w_prog_inc = r_progress + PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_prog_nxt  = r_progress;
    w_cnt_nxt   = r_idle_cnt;
    w_err_nxt   = r_err;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_prog_nxt  = '0;
      w_cnt_nxt   = '0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (in_valid && in_sym == r_pat[0]) begin
            w_prog_nxt  = PW'(1);
            w_state_nxt = (DEPTH == 1) ? S_HIT : S_MATCHING;
          end
        end
        S_MATCHING: begin
          if (in_valid) begin
            w_cnt_nxt = '0;
            if (in_sym == w_exp_sym) begin
              w_prog_nxt = w_prog_inc;
              if (w_prog_inc == PW'(DEPTH)) w_state_nxt = S_HIT;
            end else if (in_sym == r_pat[0]) begin
              w_prog_nxt = PW'(1);
            end else begin
              w_prog_nxt  = '0;
              w_state_nxt = S_IDLE;
            end
          end else if (r_idle_cnt == CW'(TIMEOUT - 1)) begin
            w_state_nxt = S_TIMEOUT;
            w_prog_nxt  = '0;
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_idle_cnt + CW'(1);
          end
        end
        S_HIT: begin
          w_cnt_nxt = '0;
          if (STICKY == 0) begin
            w_state_nxt = S_IDLE;
            w_prog_nxt  = '0;
          end
        end
        S_TIMEOUT: w_cnt_nxt = '0;
        default: begin
          w_state_nxt = S_IDLE;
          w_prog_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_progress <= '0;
      r_idle_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_progress <= w_prog_nxt;
      r_idle_cnt <= w_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign in_ready    = (r_state == S_IDLE) || (r_state == S_MATCHING);
  assign match       = (r_state == S_HIT);
  assign progress    = r_progress;
  assign status      = r_state;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_seq_match_fsm.sv
// Directed bench for seq_match_fsm: default instance plus a STICKY=1 instance.
`timescale 1ns/1ps
module tb_seq_match_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b0, clear = 1'b0, cfg_we = 1'b0, in_valid = 1'b0;
  logic [1:0] cfg_idx = '0, cfg_sym = '0, in_sym = '0;
  logic       a_ready, a_match, a_err, b_ready, b_match, b_err;
  logic [2:0] a_prog, a_status, b_prog, b_status;
  logic [1:0] pat_v [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_match_fsm dut_a (
    .clk(clk), .reset(reset), .clear(clear), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sym(cfg_sym), .in_valid(in_valid), .in_sym(in_sym), .in_ready(a_ready),
    .match(a_match), .progress(a_prog), .status(a_status), .timeout_err(a_err));

  seq_match_fsm #(.STICKY(1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sym(cfg_sym), .in_valid(in_valid), .in_sym(in_sym), .in_ready(b_ready),
    .match(b_match), .progress(b_prog), .status(b_status), .timeout_err(b_err));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sym(input logic [1:0] s);
    in_valid = 1'b1; in_sym = s; step(); in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; repeat (n) step();
  endtask

  task automatic program_pat();
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_idx = 2'(i); cfg_sym = pat_v[i]; step();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sym = 2'd3;
    in_valid = 1'b1; in_sym = 2'd0;
    step();
    reset = 1'b0; clear = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    total++; if (a_status !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", a_status); end
    total++; if (a_match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b want=0", a_match); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_ready); end
    total++; if (a_prog !== 3'd0) begin bad++; $display("FAIL reset_prog got=%0d want=0", a_prog); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", a_err); end
  endtask

  task automatic test_full_match();
    for (int i = 0; i < 4; i++) begin
      sym(pat_v[i]);
      total++; if (a_prog !== 3'(i + 1)) begin bad++; $display("FAIL full_prog%0d got=%0d want=%0d", i, a_prog, i + 1); end
      if (i < 3) begin
        total++; if (a_status !== 3'b001) begin bad++; $display("FAIL full_status%0d got=%b want=001", i, a_status); end
      end
    end
    total++; if (a_match !== 1'b1) begin bad++; $display("FAIL full_match got=%b want=1", a_match); end
    total++; if (a_status !== 3'b010) begin bad++; $display("FAIL full_hit_status got=%b want=010", a_status); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL full_hit_ready got=%b want=0", a_ready); end
    step();
    total++; if (a_match !== 1'b0) begin bad++; $display("FAIL full_match_drop got=%b want=0", a_match); end
    total++; if (a_status !== 3'b000) begin bad++; $display("FAIL full_after_status got=%b want=000", a_status); end
    total++; if (a_prog !== 3'd0) begin bad++; $display("FAIL full_after_prog got=%0d want=0", a_prog); end
  endtask

  task automatic test_restart();
    logic [1:0] s [6] = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd2, 2'd0};
    logic [2:0] p [6] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 6; i++) begin
      sym(s[i]);
      total++; if (a_prog !== p[i]) begin bad++; $display("FAIL restart_prog%0d got=%0d want=%0d", i, a_prog, p[i]); end
    end
    total++; if (a_match !== 1'b1) begin bad++; $display("FAIL restart_match got=%b want=1", a_match); end
    step();
    sym(2'd3); sym(2'd2);
    total++; if (a_status !== 3'b000) begin bad++; $display("FAIL mismatch_idle got=%b want=000", a_status); end
    total++; if (a_prog !== 3'd0) begin bad++; $display("FAIL mismatch_prog got=%0d want=0", a_prog); end
  endtask

  task automatic test_timeout();
    sym(2'd3); sym(2'd1); idle(7);
    total++; if (a_status !== 3'b001) begin bad++; $display("FAIL to_before got=%b want=001", a_status); end
    idle(1);
    total++; if (a_status !== 3'b011) begin bad++; $display("FAIL to_status got=%b want=011", a_status); end
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", a_err); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL to_ready got=%b want=0", a_ready); end
    total++; if (a_prog !== 3'd0) begin bad++; $display("FAIL to_prog got=%0d want=0", a_prog); end
    sym(2'd3);
    total++; if (a_status !== 3'b011) begin bad++; $display("FAIL to_hold got=%b want=011", a_status); end
    clear = 1'b1; step(); clear = 1'b0;
    total++; if (a_status !== 3'b000) begin bad++; $display("FAIL to_clear_status got=%b want=000", a_status); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL to_clear_err got=%b want=0", a_err); end
  endtask

  task automatic test_near_timeout();
    sym(2'd3); sym(2'd1); idle(7);
    total++; if (a_status !== 3'b001) begin bad++; $display("FAIL near_status got=%b want=001", a_status); end
    total++; if (a_prog !== 3'd2) begin bad++; $display("FAIL near_prog got=%0d want=2", a_prog); end
    sym(2'd2); sym(2'd0);
    total++; if (a_match !== 1'b1) begin bad++; $display("FAIL near_match got=%b want=1", a_match); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL near_err got=%b want=0", a_err); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) sym(pat_v[i]);
    sym(2'd3);
    total++; if (a_prog !== 3'd0) begin bad++; $display("FAIL b2b_hit_ignored got=%0d want=0", a_prog); end
    sym(2'd3); sym(2'd1); sym(2'd2); sym(2'd0);
    total++; if (a_match !== 1'b1) begin bad++; $display("FAIL b2b_match got=%b want=1", a_match); end
    step();
  endtask

  task automatic test_cfg_ignored();
    sym(2'd3);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_sym = 2'd3; step(); cfg_we = 1'b0;
    total++; if (a_prog !== 3'd1) begin bad++; $display("FAIL cfg_mid_prog got=%0d want=1", a_prog); end
    sym(2'd1); sym(2'd2); sym(2'd0);
    total++; if (a_match !== 1'b1) begin bad++; $display("FAIL cfg_mid_match got=%b want=1", a_match); end
    step();
    clear = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sym = 2'd1; in_valid = 1'b1; in_sym = 2'd3;
    step();
    clear = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    total++; if (a_prog !== 3'd0) begin bad++; $display("FAIL clr_over_sym got=%0d want=0", a_prog); end
    sym(2'd3);
    total++; if (a_prog !== 3'd1) begin bad++; $display("FAIL clr_over_cfg got=%0d want=1", a_prog); end
    sym(2'd1); sym(2'd2); sym(2'd0); step();
  endtask

  task automatic test_reset_mid();
    sym(2'd3); sym(2'd1); sym(2'd2);
    total++; if (a_prog !== 3'd3) begin bad++; $display("FAIL rmid_pre got=%0d want=3", a_prog); end
    reset = 1'b1; in_valid = 1'b1; in_sym = 2'd0; step(); reset = 1'b0; in_valid = 1'b0;
    total++; if (a_prog !== 3'd0) begin bad++; $display("FAIL rmid_prog got=%0d want=0", a_prog); end
    total++; if (a_match !== 1'b0) begin bad++; $display("FAIL rmid_match got=%b want=0", a_match); end
    step();
    total++; if (a_match !== 1'b0) begin bad++; $display("FAIL rmid_nopulse got=%b want=0", a_match); end
    sym(2'd3);
    total++; if (a_prog !== 3'd0) begin bad++; $display("FAIL rmid_pat0 got=%0d want=0", a_prog); end
    for (int i = 0; i < 4; i++) sym(2'd0);
    total++; if (a_match !== 1'b1) begin bad++; $display("FAIL rmid_zero_pat got=%b want=1", a_match); end
    step();
  endtask

  task automatic test_sticky();
    reset = 1'b1; step(); reset = 1'b0;
    program_pat();
    for (int i = 0; i < 4; i++) sym(pat_v[i]);
    for (int i = 0; i < 20; i++) begin
      total++; if (b_match !== 1'b1 || b_status !== 3'b010 || b_prog !== 3'd4) begin
        bad++; $display("FAIL sticky_hold%0d got=%b/%b/%0d want=1/010/4", i, b_match, b_status, b_prog);
      end
      step();
    end
    clear = 1'b1; in_valid = 1'b1; in_sym = 2'd3; step(); clear = 1'b0; in_valid = 1'b0;
    total++; if (b_status !== 3'b000) begin bad++; $display("FAIL sticky_clr_status got=%b want=000", b_status); end
    total++; if (b_prog !== 3'd0) begin bad++; $display("FAIL sticky_clr_prog got=%0d want=0", b_prog); end
    total++; if (b_match !== 1'b0) begin bad++; $display("FAIL sticky_clr_match got=%b want=0", b_match); end
  endtask

  initial begin
    test_reset();
    program_pat();
    test_full_match();
    test_restart();
    test_timeout();
    test_near_timeout();
    test_back_to_back();
    test_cfg_ignored();
    test_reset_mid();
    test_sticky();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
